// File: rtl/latch_deserializer.sv
// Deserializes bits held by an upstream transparent latch into WIDTH-bit words, sampling
// q on each synchronized fall of the latch enable; words leave on a valid/ready stage.
module latch_deserializer #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     latch_q,
    input  logic                     latch_en,
    input  logic                     clear,
    output logic [WIDTH-1:0]         data,
    output logic                     valid,
    input  logic                     ready,
    output logic [$clog2(WIDTH):0]   bit_count,
    output logic                     overrun
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    logic [SYNC_STAGES-1:0] en_sync;
    logic [SYNC_STAGES-1:0] q_sync;
    logic                   en_d;
    logic                   en_s;
    logic                   q_s;
    logic                   fall;
    logic                   complete;
    logic [WIDTH-1:0]       shreg_q;
    logic [WIDTH-1:0]       shreg_d;
    logic [WIDTH-1:0]       word;
    logic [CW-1:0]          count_d;
    logic [WIDTH-1:0]       data_d;
    logic                   valid_d;
    logic                   overrun_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            en_sync   <= '0;
            q_sync    <= '0;
            en_d      <= 1'b0;
            shreg_q   <= '0;
            bit_count <= '0;
            data      <= '0;
            valid     <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            en_sync   <= {en_sync[SYNC_STAGES-2:0], latch_en};
            q_sync    <= {q_sync[SYNC_STAGES-2:0], latch_q};
            en_d      <= en_s;
            shreg_q   <= shreg_d;
            bit_count <= count_d;
            data      <= data_d;
            valid     <= valid_d;
            overrun   <= overrun_d;
        end
    end

    always_comb begin
        en_s      = en_sync[SYNC_STAGES-1];
        q_s       = q_sync[SYNC_STAGES-1];
        // Latch output is stable while enable is low, so sample only on the close event.
        fall      = en_d & ~en_s;
        word      = {shreg_q[WIDTH-2:0], q_s};
        complete  = 1'b0;
        shreg_d   = shreg_q;
        count_d   = bit_count;
        data_d    = data;
        valid_d   = valid;
        overrun_d = overrun;

        if (clear) begin
            count_d   = '0;
            overrun_d = 1'b0;
        end else if (fall) begin
            shreg_d = word;
            if (bit_count == CW'(WIDTH - 1)) begin
                complete = 1'b1;
                count_d  = '0;
            end else begin
                count_d = bit_count + CW'(1);
            end
        end

        if (valid && ready) begin
            valid_d = 1'b0;
        end
        if (complete) begin
            if (!valid || ready) begin
                data_d  = word;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_latch_deserializer.sv
// Directed bench for latch_deserializer: drives latch pulses on the falling clock edge and
// checks outputs on falling edges against hand-computed words and timing.
module tb_latch_deserializer;

    localparam int unsigned WIDTH = 8;

    logic             clock = 1'b0;
    logic             reset;
    logic             latch_q;
    logic             latch_en;
    logic             clear;
    logic [WIDTH-1:0] data;
    logic             valid;
    logic             ready;
    logic [3:0]       bit_count;
    logic             overrun;

    int checks = 0;
    int errors = 0;

    latch_deserializer #(.WIDTH(WIDTH), .SYNC_STAGES(2)) dut (
        .clock     (clock),
        .reset     (reset),
        .latch_q   (latch_q),
        .latch_en  (latch_en),
        .clear     (clear),
        .data      (data),
        .valid     (valid),
        .ready     (ready),
        .bit_count (bit_count),
        .overrun   (overrun)
    );

    always #5 clock = ~clock;

    // Raise enable with bit b for 3 cycles, then drop it; returns at the negedge of the drop.
    task automatic drop_en(input logic b);
        @(negedge clock);
        latch_q  = b;
        latch_en = 1'b1;
        repeat (3) @(negedge clock);
        latch_en = 1'b0;
    endtask

    // Full bit: drop, then wait until the shift has landed.
    task automatic send_bit(input logic b);
        drop_en(b);
        repeat (3) @(negedge clock);
    endtask

    task automatic send_word(input logic [WIDTH-1:0] w);
        for (int i = WIDTH - 1; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic test_reset_idle;
        reset = 1'b1; latch_q = 1'b0; latch_en = 1'b0; clear = 1'b0; ready = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            checks++;
            if (data !== 8'h00 || valid !== 1'b0 || bit_count !== 4'd0 || overrun !== 1'b0) begin
                errors++;
                $display("FAIL idle cyc %0d: data=%h valid=%b cnt=%0d ovr=%b, want 00 0 0 0",
                         i, data, valid, bit_count, overrun);
            end
        end
    endtask

    task automatic test_word_ready;
        logic [7:0] w;
        w = 8'hA5;
        ready = 1'b1;
        for (int i = 7; i >= 1; i--) send_bit(w[i]);
        checks++;
        if (bit_count !== 4'd7) begin
            errors++; $display("FAIL a5 count7: got %0d want 7", bit_count);
        end
        drop_en(w[0]);
        @(negedge clock);
        checks++;
        if (valid !== 1'b0) begin errors++; $display("FAIL a5 early N: valid=%b want 0", valid); end
        @(negedge clock);
        checks++;
        if (valid !== 1'b0) begin errors++; $display("FAIL a5 early N+1: valid=%b want 0", valid); end
        @(negedge clock);
        checks++;
        if (valid !== 1'b1 || data !== 8'hA5 || bit_count !== 4'd0) begin
            errors++;
            $display("FAIL a5 out: valid=%b data=%h cnt=%0d want 1 a5 0", valid, data, bit_count);
        end
        @(negedge clock);
        checks++;
        if (valid !== 1'b0) begin errors++; $display("FAIL a5 one-cycle: valid=%b want 0", valid); end
        ready = 1'b0;
    endtask

    task automatic test_overrun;
        ready = 1'b0;
        send_word(8'hA5);
        checks++;
        if (valid !== 1'b1 || data !== 8'hA5 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL ovr first: valid=%b data=%h ovr=%b want 1 a5 0", valid, data, overrun);
        end
        send_word(8'h3C);
        checks++;
        if (valid !== 1'b1 || data !== 8'hA5 || overrun !== 1'b1) begin
            errors++;
            $display("FAIL ovr drop: valid=%b data=%h ovr=%b want 1 a5 1", valid, data, overrun);
        end
        ready = 1'b1;
        @(negedge clock);
        ready = 1'b0;
        checks++;
        if (valid !== 1'b0 || overrun !== 1'b1) begin
            errors++; $display("FAIL ovr accept: valid=%b ovr=%b want 0 1", valid, overrun);
        end
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        checks++;
        if (overrun !== 1'b0 || valid !== 1'b0 || data !== 8'hA5) begin
            errors++;
            $display("FAIL ovr clear: ovr=%b valid=%b data=%h want 0 0 a5", overrun, valid, data);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] w;
        w = 8'h01;
        ready = 1'b0;
        send_word(8'hFF);
        checks++;
        if (valid !== 1'b1 || data !== 8'hFF) begin
            errors++; $display("FAIL b2b first: valid=%b data=%h want 1 ff", valid, data);
        end
        for (int i = 7; i >= 1; i--) send_bit(w[i]);
        drop_en(w[0]);
        @(negedge clock);
        @(negedge clock);
        checks++;
        if (valid !== 1'b1 || data !== 8'hFF) begin
            errors++; $display("FAIL b2b hold: valid=%b data=%h want 1 ff", valid, data);
        end
        ready = 1'b1;
        @(negedge clock);
        ready = 1'b0;
        checks++;
        if (valid !== 1'b1 || data !== 8'h01 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL b2b swap: valid=%b data=%h ovr=%b want 1 01 0", valid, data, overrun);
        end
        ready = 1'b1;
        @(negedge clock);
        ready = 1'b0;
    endtask

    task automatic test_clear_fall;
        ready = 1'b0;
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        checks++;
        if (bit_count !== 4'd5) begin errors++; $display("FAIL clr count5: got %0d want 5", bit_count); end
        drop_en(1'b1);
        @(negedge clock);
        @(negedge clock);
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        checks++;
        if (bit_count !== 4'd0) begin errors++; $display("FAIL clr fall: got %0d want 0", bit_count); end
        repeat (2) @(negedge clock);
        send_word(8'h5A);
        checks++;
        if (valid !== 1'b1 || data !== 8'h5A || overrun !== 1'b0) begin
            errors++;
            $display("FAIL clr word: valid=%b data=%h ovr=%b want 1 5a 0", valid, data, overrun);
        end
        ready = 1'b1;
        @(negedge clock);
        ready = 1'b0;
    endtask

    task automatic test_async_reset;
        ready = 1'b0;
        send_word(8'hC3);
        send_word(8'h3C);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        checks++;
        if (valid !== 1'b1 || data !== 8'hC3 || overrun !== 1'b1 || bit_count !== 4'd3) begin
            errors++;
            $display("FAIL rst pre: valid=%b data=%h ovr=%b cnt=%0d want 1 c3 1 3",
                     valid, data, overrun, bit_count);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (valid !== 1'b0 || data !== 8'h00 || overrun !== 1'b0 || bit_count !== 4'd0) begin
            errors++;
            $display("FAIL rst async: valid=%b data=%h ovr=%b cnt=%0d want 0 00 0 0",
                     valid, data, overrun, bit_count);
        end
        @(negedge clock);
        reset = 1'b0;
        repeat (6) @(negedge clock);
        checks++;
        if (bit_count !== 4'd0 || valid !== 1'b0) begin
            errors++; $display("FAIL rst spurious: cnt=%0d valid=%b want 0 0", bit_count, valid);
        end
        send_word(8'h96);
        checks++;
        if (valid !== 1'b1 || data !== 8'h96 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL rst word: valid=%b data=%h ovr=%b want 1 96 0", valid, data, overrun);
        end
    endtask

    initial begin
        test_reset_idle;
        test_word_ready;
        test_overrun;
        test_back_to_back;
        test_clear_fall;
        test_async_reset;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
